// File: rtl/eth_cmd_enc.sv
// rtl/eth_cmd_enc.sv - register record queue and byte-serial frame encoder for the UDP control TX FIFO
//
// Takes (address, data) register records, queues them QDEPTH deep and emits
// each one as a framed byte stream on the TX FIFO write port:
//   HDR0 HDR1 addr d[31:24] d[23:16] d[15:8] d[7:0] [checksum] TAIL
// Optional feature macro: CMD_ENC_CHKSUM_EN inserts the checksum byte
// (addr + four data bytes, mod 256) between d[7:0] and TAIL.
//
// Ports:
//   clk          system clock (clk_50M)
//   reset_n      asynchronous active-low reset
//   cmd_valid    record present this cycle
//   cmd_addr     register address
//   cmd_data     register data
//   cmd_ready    queue has room (from registered count only)
//   fifo_full    TX FIFO full, same clock domain, used combinationally
//   fifo_wrreq   TX FIFO write strobe
//   fifo_wrdata  byte written to TX FIFO
//   busy         frame in progress or queue non-empty (registered)
//   frame_done   one-cycle pulse after the TAIL byte is written
//   drop_cnt     records discarded while the queue was full, saturating

module eth_cmd_enc #(
  parameter logic [7:0] HDR0   = 8'h55,
  parameter logic [7:0] HDR1   = 8'hA5,
  parameter logic [7:0] TAIL   = 8'hF0,
  parameter int         QDEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  input  logic        fifo_full,
  output logic        fifo_wrreq,
  output logic [7:0]  fifo_wrdata,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  typedef enum logic [3:0] {
    IDLE,
    S_H0,
    S_H1,
    S_AD,
    S_D3,
    S_D2,
    S_D1,
    S_D0,
`ifdef CMD_ENC_CHKSUM_EN
    S_CK,
`endif
    S_TL
  } state_e;

  // Queue storage: {addr, data} per entry
  logic [39:0]    mem_q [QDEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Frame registers hold the record being serialised
  logic [7:0]     addr_q, addr_d;
  logic [31:0]    data_q, data_d;

  state_e         state_q, state_d;
  logic           busy_q, busy_d;
  logic           frame_done_q, frame_done_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;

  logic           push;
  logic           drop;
  logic           pop;
  logic           wr;
  logic           q_nempty;

  assign cmd_ready  = (cnt_q != FULL_CNT);
  assign push       = cmd_valid && cmd_ready;
  assign drop       = cmd_valid && !cmd_ready;
  assign q_nempty   = (cnt_q != '0);
  assign wr         = (state_q != IDLE) && !fifo_full;

  // A new record is loaded either from idle or straight after a TAIL write,
  // which is what gives back-to-back frames without a gap byte.
  assign pop        = q_nempty && ((state_q == IDLE) || ((state_q == S_TL) && wr));

  assign fifo_wrreq = wr;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign drop_cnt   = drop_cnt_q;

`ifdef CMD_ENC_CHKSUM_EN
  logic [7:0] chk;
  assign chk = addr_q + data_q[31:24] + data_q[23:16] + data_q[15:8] + data_q[7:0];
`endif

  // Byte mux; IDLE drives zero so the write bus is quiet between frames
  always_comb begin
    fifo_wrdata = 8'h00;
    case (state_q)
      S_H0:    fifo_wrdata = HDR0;
      S_H1:    fifo_wrdata = HDR1;
      S_AD:    fifo_wrdata = addr_q;
      S_D3:    fifo_wrdata = data_q[31:24];
      S_D2:    fifo_wrdata = data_q[23:16];
      S_D1:    fifo_wrdata = data_q[15:8];
      S_D0:    fifo_wrdata = data_q[7:0];
`ifdef CMD_ENC_CHKSUM_EN
      S_CK:    fifo_wrdata = chk;
`endif
      S_TL:    fifo_wrdata = TAIL;
      default: fifo_wrdata = 8'h00;
    endcase
  end

  // Next state: byte states advance only on an accepted write
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (q_nempty) state_d = S_H0;
      S_H0:    if (wr) state_d = S_H1;
      S_H1:    if (wr) state_d = S_AD;
      S_AD:    if (wr) state_d = S_D3;
      S_D3:    if (wr) state_d = S_D2;
      S_D2:    if (wr) state_d = S_D1;
      S_D1:    if (wr) state_d = S_D0;
`ifdef CMD_ENC_CHKSUM_EN
      S_D0:    if (wr) state_d = S_CK;
      S_CK:    if (wr) state_d = S_TL;
`else
      S_D0:    if (wr) state_d = S_TL;
`endif
      S_TL:    if (wr) state_d = q_nempty ? S_H0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d        = cnt_q + CW'(push) - CW'(pop);
    addr_d       = pop ? mem_q[rd_ptr_q][39:32] : addr_q;
    data_d       = pop ? mem_q[rd_ptr_q][31:0]  : data_q;
    // busy lags the state by one edge: it rises the edge after a push and
    // falls the edge after the final TAIL write
    busy_d       = (state_q != IDLE) || q_nempty;
    frame_done_d = (state_q == S_TL) && wr;
    drop_cnt_d   = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      addr_q       <= 8'h00;
      data_q       <= 32'h0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      drop_cnt_q   <= 16'h0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Queue payload needs no reset; occupancy is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_addr, cmd_data};
    end
  end

endmodule

// File: tb/tb_eth_cmd_enc.sv
// tb/tb_eth_cmd_enc.sv - scoreboard bench for eth_cmd_enc

module tb_eth_cmd_enc;

`ifdef CMD_ENC_CHKSUM_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic        fifo_full;
  logic        fifo_wrreq;
  logic [7:0]  fifo_wrdata;
  logic        busy;
  logic        frame_done;
  logic [15:0] drop_cnt;

  eth_cmd_enc #(
    .HDR0(8'h55), .HDR1(8'hA5), .TAIL(8'hF0), .QDEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .fifo_full(fifo_full),
    .fifo_wrreq(fifo_wrreq), .fifo_wrdata(fifo_wrdata),
    .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;
  int first_wr_cyc = 0;
  int last_wr_cyc = 0;
  bit mark_first = 1'b0;
  logic [7:0] sb_exp;
  logic [7:0] sbq[$];

  always @(posedge clk) cyc++;

  // Output monitor: every written byte is popped from the scoreboard
  always @(negedge clk) begin
    if (reset_n === 1'b1 && fifo_wrreq === 1'b1) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected got=%02h expected=none cyc=%0d", fifo_wrdata, cyc);
      end else begin
        sb_exp = sbq.pop_front();
        if (fifo_wrdata !== sb_exp) begin
          n_err++;
          $display("FAIL wr_byte got=%02h expected=%02h cyc=%0d", fifo_wrdata, sb_exp, cyc);
        end
      end
      if (mark_first) begin
        first_wr_cyc = cyc;
        mark_first = 1'b0;
      end
      last_wr_cyc = cyc;
      wr_cnt++;
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  task automatic push_rec(input logic [7:0] a, input logic [31:0] d, input bit acc);
    logic [7:0] s;
    s = a + d[31:24] + d[23:16] + d[15:8] + d[7:0];
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    if (acc) begin
      sbq.push_back(8'h55);
      sbq.push_back(8'hA5);
      sbq.push_back(a);
      sbq.push_back(d[31:24]);
      sbq.push_back(d[23:16]);
      sbq.push_back(d[15:8]);
      sbq.push_back(d[7:0]);
`ifdef CMD_ENC_CHKSUM_EN
      sbq.push_back(s);
`endif
      sbq.push_back(8'hF0);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && busy === 1'b0 && fifo_wrreq === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_drain_timeout got=%0d_bytes_left expected=0", nm, sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({fifo_wrreq, fifo_wrdata, busy, frame_done, drop_cnt, cmd_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_outputs got=%b_%02h_%b_%b_%04h_%b expected=0_00_0_0_0000_1",
               fifo_wrreq, fifo_wrdata, busy, frame_done, drop_cnt, cmd_ready);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({fifo_wrreq, busy, cmd_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL reset_idle got=%b%b%b expected=001", fifo_wrreq, busy, cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int fd0, w0, pc;
    fd0 = fd_cnt;
    w0 = wr_cnt;
    mark_first = 1'b1;
    push_rec(8'h03, 32'h0000_1234, 1'b1);
    pc = cyc;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_busy_mid got=%b expected=1", busy);
    end
    wait_drain("single");
    n_cmp++;
    if (first_wr_cyc !== pc + 1) begin
      n_err++;
      $display("FAIL single_first_latency got=%0d expected=%0d", first_wr_cyc, pc + 1);
    end
    n_cmp++;
    if (wr_cnt - w0 !== FL || last_wr_cyc - first_wr_cyc !== FL - 1) begin
      n_err++;
      $display("FAIL single_contiguous got=%0d_writes_span_%0d expected=%0d_span_%0d",
               wr_cnt - w0, last_wr_cyc - first_wr_cyc, FL, FL - 1);
    end
    n_cmp++;
    if (fd_cnt - fd0 !== 1 || fd_cyc !== last_wr_cyc + 1) begin
      n_err++;
      $display("FAIL single_frame_done got=%0d_at_%0d expected=1_at_%0d",
               fd_cnt - fd0, fd_cyc, last_wr_cyc + 1);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_busy_fall got=%b expected=0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int fd0, w0;
    fd0 = fd_cnt;
    w0 = wr_cnt;
    mark_first = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_rec(8'($urandom_range(0, 255)), $urandom, 1'b1);
    end
    wait_drain("b2b");
    n_cmp++;
    if (wr_cnt - w0 !== 3 * FL || last_wr_cyc - first_wr_cyc !== 3 * FL - 1) begin
      n_err++;
      $display("FAIL b2b_contiguous got=%0d_writes_span_%0d expected=%0d_span_%0d",
               wr_cnt - w0, last_wr_cyc - first_wr_cyc, 3 * FL, 3 * FL - 1);
    end
    n_cmp++;
    if (fd_cnt - fd0 !== 3) begin
      n_err++;
      $display("FAIL b2b_frame_done got=%0d expected=3", fd_cnt - fd0);
    end
  endtask

  task automatic test_backpressure();
    int w0, wh;
    bit seen;
    w0 = wr_cnt;
    seen = 1'b0;
    push_rec(8'h5A, 32'hDEAD_BEEF, 1'b1);
    // after four writes the encoder is presenting data[23:16]
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (wr_cnt == w0 + 4) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL bp_reach_d2 got=%0d_writes expected=4", wr_cnt - w0);
    end
    fifo_full = 1'b1;
    wh = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (fifo_wrreq !== 1'b0) begin
        n_err++;
        $display("FAIL bp_wrreq_while_full got=%b expected=0", fifo_wrreq);
      end
    end
    @(posedge clk); #1;
    fifo_full = 1'b0;
    n_cmp++;
    if (wr_cnt !== wh) begin
      n_err++;
      $display("FAIL bp_writes_held got=%0d expected=%0d", wr_cnt, wh);
    end
    wait_drain("bp");
    n_cmp++;
    if (wr_cnt - w0 !== FL) begin
      n_err++;
      $display("FAIL bp_total got=%0d expected=%0d", wr_cnt - w0, FL);
    end
  endtask

  task automatic test_overflow();
    int fd0, w0;
    fd0 = fd_cnt;
    w0 = wr_cnt;
    fifo_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
          n_err++;
          $display("FAIL ovf_ready_before_5 got=%b expected=1", cmd_ready);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
          n_err++;
          $display("FAIL ovf_ready_before_6 got=%b expected=0", cmd_ready);
        end
      end
      push_rec(8'h10 + 8'(i), 32'h1111_0000 + 32'(i * 32'h0101), i < 5);
    end
    n_cmp++;
    if (drop_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL ovf_drop_cnt got=%0d expected=1", drop_cnt);
    end
    n_cmp++;
    if (wr_cnt !== w0) begin
      n_err++;
      $display("FAIL ovf_no_write_full got=%0d expected=%0d", wr_cnt, w0);
    end
    repeat (3) @(posedge clk);
    #1;
    fifo_full = 1'b0;
    wait_drain("ovf");
    n_cmp++;
    if (fd_cnt - fd0 !== 5 || wr_cnt - w0 !== 5 * FL) begin
      n_err++;
      $display("FAIL ovf_frames got=%0d_frames_%0d_bytes expected=5_frames_%0d_bytes",
               fd_cnt - fd0, wr_cnt - w0, 5 * FL);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    bit seen;
    w0 = wr_cnt;
    seen = 1'b0;
    push_rec(8'h77, 32'hCAFE_F00D, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (wr_cnt == w0 + 3) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL rst_reach_d3 got=%0d_writes expected=3", wr_cnt - w0);
    end
    reset_n = 1'b0;
    #1;
    sbq.delete();
    n_cmp++;
    if ({fifo_wrreq, fifo_wrdata, busy, frame_done, drop_cnt, cmd_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_mid_outputs got=%b_%02h_%b_%b_%04h_%b expected=0_00_0_0_0000_1",
               fifo_wrreq, fifo_wrdata, busy, frame_done, drop_cnt, cmd_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    w0 = wr_cnt;
    push_rec(8'h21, 32'h0102_0304, 1'b1);
    wait_drain("rst_after");
    n_cmp++;
    if (wr_cnt - w0 !== FL) begin
      n_err++;
      $display("FAIL rst_clean_frame got=%0d expected=%0d", wr_cnt - w0, FL);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = 8'h00;
    cmd_data  = 32'h0;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
